// File: rtl/alu.sv
// 32-bit RISC-V ALU: shared 33-bit adder for add/sub/compare, logic ops and
// pass-B, with result and Z/N/C/V flags registered for one cycle of latency.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Negative,
  output logic        Carry,
  output logic        OverFlow
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLTU = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  alu_op_e     op;
  logic        sub;
  logic        arith;
  logic [31:0] bx;
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] res;

  assign op    = alu_op_e'(ALUControl);
  assign sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign arith = (op == OP_ADD) || (op == OP_SUB);
  assign bx    = sub ? ~B : B;
  assign sum   = {1'b0, A} + {1'b0, bx} + {32'd0, sub};

  // Overflow is judged on the operand actually fed to the adder, so SLT
  // can reuse it to correct the sign bit across a subtract overflow.
  assign ovf   = (A[31] == bx[31]) && (sum[31] != A[31]);

  always_comb begin
    res = 32'd0;
    case (op)
      OP_ADD, OP_SUB: res = sum[31:0];
      OP_AND:         res = A & B;
      OP_OR:          res = A | B;
      OP_XOR:         res = A ^ B;
      OP_SLT:         res = {31'd0, sum[31] ^ ovf};
      OP_SLTU:        res = {31'd0, ~sum[32]};
      OP_PASS:        res = B;
      default:        res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      Result   <= 32'd0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      OverFlow <= 1'b0;
    end else begin
      Result   <= res;
      Zero     <= (res == 32'd0);
      Negative <= res[31];
      Carry    <= arith & sum[32];
      OverFlow <= arith & ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed plan vectors, reset/hold checks, then random ops
// compared against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  ALUControl;
  logic [31:0] Result;
  logic        Zero, Negative, Carry, OverFlow;

  int nvec = 0;
  int nerr = 0;

  alu dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUControl(ALUControl),
    .Result(Result), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .OverFlow(OverFlow)
  );

  always #5 clk = ~clk;

  // Reference: {Result, Z, N, C, V} from plain signed/unsigned arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = 32'd0;
    case (op)
      3'd0: begin
        full = ua + ub;
        r = full[31:0];
        c = (full >= 64'sd4294967296);
        full = sa + sb;
        v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd1: begin
        full = ua - ub;
        r = full[31:0];
        c = (ua >= ub);
        full = sa - sb;
        v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = (ua < ub) ? 32'd1 : 32'd0;
      default: r = b;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  task automatic check(input string tag, input logic [35:0] exp);
    logic [35:0] obs;
    obs = {Result, Zero, Negative, Carry, OverFlow};
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got R=%h ZNCV=%b expected R=%h ZNCV=%b",
             tag, obs[35:4], obs[3:0], exp[35:4], exp[3:0]);
    end
  endtask

  // Drive one operation mid-cycle, sample just after the capturing edge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op);
    @(negedge clk);
    A = a; B = b; ALUControl = op;
    @(posedge clk);
    #1;
    check(tag, model(a, b, op));
  endtask

  initial begin
    logic [35:0] held;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    rst = 1'b0; A = 32'd5; B = 32'd3; ALUControl = 3'd0;
    @(posedge clk); #1; check("reset_edge1", 36'h0);
    @(posedge clk); #1; check("reset_edge2", 36'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; check("reset_release_add", {32'd8, 4'b0000});

    step("add_5_3",   32'd5, 32'd3, 3'd0);
    step("sub_5_3",   32'd5, 32'd3, 3'd1);
    step("and",       32'h5, 32'h3, 3'd2);
    step("or",        32'h5, 32'h3, 3'd3);
    step("xor",       32'h5, 32'h3, 3'd4);
    step("pass",      32'h5, 32'h3, 3'd7);
    step("slt_3_5",   32'd3, 32'd5, 3'd5);
    step("slt_5_3",   32'd5, 32'd3, 3'd5);
    step("slt_min_1", 32'h8000_0000, 32'd1, 3'd5);
    step("sltu_min_1",32'h8000_0000, 32'd1, 3'd6);
    step("sltu_3_5",  32'd3, 32'd5, 3'd6);
    step("sub_3_3",   32'd3, 32'd3, 3'd1);
    step("sub_3_5",   32'd3, 32'd5, 3'd1);
    step("add_ovf",   32'h7FFF_FFFF, 32'd1, 3'd0);
    step("add_wrap",  32'hFFFF_FFFF, 32'd1, 3'd0);
    step("sub_ovf",   32'h8000_0000, 32'd1, 3'd1);

    // A few absolute expectations so the model itself is anchored.
    step("slt_min_1_abs", 32'h8000_0000, 32'd1, 3'd5);
    check("slt_min_1_const", {32'd1, 4'b0000});
    step("sub_3_5_abs", 32'd3, 32'd5, 3'd1);
    check("sub_3_5_const", {32'hFFFF_FFFE, 4'b0100});
    step("add_ovf_abs", 32'h7FFF_FFFF, 32'd1, 3'd0);
    check("add_ovf_const", {32'h8000_0000, 4'b0101});

    // Inputs changing between edges must not disturb the held outputs.
    held = model(32'h7FFF_FFFF, 32'd1, 3'd0);
    A = 32'd0; B = 32'd0; ALUControl = 3'd1;
    #2;
    check("hold_between_edges", held);
    @(posedge clk); #1; check("sampled_after_change", model(32'd0, 32'd0, 3'd1));

    // Mid-stream reset discards the in-flight op; first released edge registers.
    @(negedge clk); rst = 1'b0; A = 32'hFFFF_FFFF; B = 32'd1; ALUControl = 3'd0;
    @(posedge clk); #1; check("midstream_reset", 36'h0);
    @(negedge clk); rst = 1'b1; A = 32'd3; B = 32'd3; ALUControl = 3'd1;
    @(posedge clk); #1; check("first_after_reset", {32'd0, 4'b1010});

    // Random ops, a new one every cycle, with some corner-biased operands.
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: rb = ra;
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      step("random", ra, rb, rop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
